drbg_access_scheduler: RTL

//  Sequences the double hash DRBG for the video scrambler: drives one-time init, reseeds at each

---
 rtl/drbg_access_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/drbg_access_scheduler.sv
// drbg_access_scheduler
// Sequences the shared hash DRBG: one-time init, a reseed after every rising
// edge of vertical blanking, and round-robin sharing of next_bits among
// NUM_REQ consumers. A watchdog moves the block into a sticky fault if the
// DRBG stops answering.
//
// Consumer handshake: a consumer raises req[i] as a level and holds it until
// it sees its one-cycle rsp_valid[i] pulse; rsp_data is valid only in that
// cycle. Dropping req[i] before it is granted withdraws the request. Once
// granted, the grant does not change until the response is delivered.
module drbg_access_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = 256,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  V,
    output logic                  drbg_init,
    input  logic                  drbg_init_ready,
    output logic                  drbg_next_seed,
    output logic                  drbg_next_bits,
    input  logic                  drbg_bits_ready,
    input  logic                  drbg_busy,
    input  logic [DATA_WIDTH-1:0] drbg_bits,
    input  logic [NUM_REQ-1:0]    req,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  ready,
    output logic                  fault,
    output logic [2:0]            dbg_state
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_RESEED  = 3'd2,
        ST_RS_WAIT = 3'd3,
        ST_REQ     = 3'd4,
        ST_B_WAIT  = 3'd5,
        ST_FAULT   = 3'd6
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            prev_v;
    logic            v_rise;
    logic            vsync_pend;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   grant;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   cand;
    logic [PW:0]     sum;
    logic            found;
    logic [TW-1:0]   timer;
    logic            counting;
    logic            timeout;
    logic [NUM_REQ-1:0] grant_onehot;

    assign v_rise       = V & ~prev_v;
    assign counting     = (state == ST_INIT) || (state == ST_RS_WAIT) || (state == ST_B_WAIT);
    assign timeout      = counting && (timer == TW'(TIMEOUT_CYCLES - 1));
    assign grant_onehot = NUM_REQ'(1) << grant;
    assign dbg_state    = state;

    // Round-robin search: first active request at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NUM_REQ)) begin
                sum = sum - (PW+1)'(NUM_REQ);
            end
            cand = sum[PW-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state logic; a DRBG answer in the same cycle as the timeout wins.
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: begin
                if (drbg_init_ready)   state_next = ST_IDLE;
                else if (timeout)      state_next = ST_FAULT;
            end
            ST_IDLE: begin
                if (vsync_pend || v_rise) state_next = ST_RESEED;
                else if (found)           state_next = ST_REQ;
            end
            ST_RESEED:  state_next = ST_RS_WAIT;
            ST_RS_WAIT: begin
                // timer==0 marks the first cycle, where busy may not have risen yet
                if ((timer != '0) && !drbg_busy) state_next = ST_IDLE;
                else if (timeout)                state_next = ST_FAULT;
            end
            ST_REQ:     state_next = ST_B_WAIT;
            ST_B_WAIT: begin
                if (drbg_bits_ready)   state_next = ST_IDLE;
                else if (timeout)      state_next = ST_FAULT;
            end
            ST_FAULT:   state_next = ST_FAULT;
            default:    state_next = ST_INIT;
        endcase
    end

    // State register, watchdog timer and vsync edge capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_INIT;
            timer      <= '0;
            prev_v     <= 1'b0;
            vsync_pend <= 1'b0;
        end else begin
            state  <= state_next;
            prev_v <= V;
            if (state_next != state) timer <= '0;
            else if (counting)       timer <= timer + TW'(1);
            if (v_rise)                   vsync_pend <= 1'b1;
            else if (state == ST_RESEED)  vsync_pend <= 1'b0;
        end
    end

    // Registered outputs, grant latch and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            drbg_init      <= 1'b0;
            drbg_next_seed <= 1'b0;
            drbg_next_bits <= 1'b0;
            rsp_valid      <= '0;
            rsp_data       <= '0;
            ready          <= 1'b0;
            fault          <= 1'b0;
            rr_ptr         <= '0;
            grant          <= '0;
        end else begin
            drbg_init      <= (state_next == ST_INIT);
            drbg_next_seed <= (state == ST_RESEED);
            drbg_next_bits <= (state == ST_REQ);
            ready          <= (state_next != ST_INIT) && (state_next != ST_FAULT);
            fault          <= (state_next == ST_FAULT);
            rsp_valid      <= '0;
            if (state == ST_IDLE && state_next == ST_REQ) begin
                grant <= pick;
            end
            if (state == ST_B_WAIT && drbg_bits_ready) begin
                rsp_valid <= grant_onehot;
                rsp_data  <= drbg_bits;
                rr_ptr    <= (grant == PW'(NUM_REQ - 1)) ? '0 : grant + PW'(1);
            end
        end
    end

endmodule
